hilo_muldiv_unit: RTL
=====================

// Module: hilo_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit that owns the HI/LO register pair of the MIPS datapath.
//  Sits beside the ALU in the execute stage: the control unit issues an Op with operands
//  rs (A) and rt (B); the unit holds Busy for the PC-stall logic and drives HiData/LoData,
//  which feed the mfhi/mflo write-back mux and the top-level debug outputs.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iterations per mul/div = WIDTH
// PORTS
//  Clk     in   1      system clock, all state updates on rising edge
//  Rst     in   1      asynchronous, active-high reset
//  Start   in   1      issue request; sampled on a rising edge only when Busy=0
//  Op      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO
//  A       in   WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO source)
//  B       in   WIDTH  rt operand (multiplier or divisor)
//  Busy    out  1      high while an iterative op is in flight; stall request to the PC
//  Done    out  1      one-cycle pulse after HI/LO take the final result
//  HiData  out  WIDTH  current HI register
//  LoData  out  WIDTH  current LO register
// BEHAVIOUR
//  Reset (async, any time, including mid-op): state=IDLE, HI=LO=0, Busy=0, Done=0,
//   iteration counter=0, all internal operand registers cleared.
//  FSM states: IDLE, MUL, DIV, FIX.
//   IDLE: Start&Op=MTHI -> HI<=A; Start&Op=MTLO -> LO<=A; both at edge E0; Done=1 for the
//    following cycle; state stays IDLE; Busy is never raised.
//   IDLE: Start & mul-class op (MULT/MULTU/MADD/MSUB) -> latch |A|,|B| (magnitudes for
//    signed ops, raw values for MULTU), result sign = A[W-1]^B[W-1] (signed ops), -> MUL.
//   IDLE: Start & DIV/DIVU -> latch magnitudes, quotient sign = A[W-1]^B[W-1],
//    remainder sign = A[W-1] (DIV only), -> DIV.
//   MUL: shift-add, one multiplier bit per edge, WIDTH edges (E1..EW), then -> FIX.
//   DIV: restoring, one quotient bit per edge, WIDTH edges (E1..EW), then -> FIX.
//   FIX (one edge, EW+1): apply sign fixup and write HI/LO, -> IDLE, Done=1 next cycle.
//  Busy=1 from the cycle after E0 through the cycle ending at EW+1 (exactly WIDTH+1 cycles).
//  Results: MULT/MULTU {HI,LO}=2W-bit product; MADD {HI,LO}+=signed product;
//   MSUB {HI,LO}-=signed product (accumulate uses HI/LO as read at EW+1, wraps mod 2^(2W)).
//   DIV/DIVU LO=quotient, HI=remainder; signed quotient truncates toward zero.
//  Divide by zero (B=0): no iteration; HI<=A, LO<=all-ones; Done pulses
//   after edge EW+1 so latency is identical to a normal divide.
//  DIV of most-negative by -1: LO=0x80000000, HI=0 (wraps, no trap).
//  HI/LO are not modified until the FIX edge; HiData/LoData show old values while Busy=1.
//  Start while Busy=1: ignored, no effect on operands or state.
//  Start in the Done cycle: accepted (state is already IDLE).
//  Op values are decoded only at E0; A/B/Op may change freely while Busy.
// TESTING
//  1. MULT A=0xFFFFFFFD(-3), B=7 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB,
//     Busy high exactly 33 cycles, Done exactly one cycle.
//  2. MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
//  3. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
//  4. DIVU A=5, B=0 -> HI=5, LO=0xFFFFFFFF, same 33-cycle Busy window as test 3.
//  5. MTLO 0xFFFFFFFF, MTHI 0 (no Busy, Done each) then MADD 1*1 -> HI=1, LO=0;
//     MSUB 1*1 -> HI=0, LO=0xFFFFFFFF.
//  6. Start MULT 5*5, pulse Rst mid-iteration 10 -> Busy=0, HI=LO=0 immediately;
//     a second Start issued while Busy before reset is ignored (result unaffected).

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit that owns the HI/LO register pair.
// MUL and DIV run one bit per clock for WIDTH clocks on operand magnitudes, then a single
// FIX clock applies the sign correction (and accumulate for MADD/MSUB) and writes HI/LO.
// The unit has no result pipeline, so operands are held in registers for the whole op.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiData,
    output logic [WIDTH-1:0] LoData
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    // MUL: {partial product, remaining multiplier bits}; DIV: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2:0]           op_q, op_d;
    logic                 qneg_q, qneg_d;   // negate product / quotient at FIX
    logic                 rneg_q, rneg_d;   // negate remainder at FIX (DIV only)
    logic                 dvz_q, dvz_d;     // divisor was zero: skip iteration
    logic                 done_q, done_d;

    // Issue-time decode: signed ops work on magnitudes, sign is restored at FIX.
    logic                 is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign is_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;

    // Shift-add step: add multiplicand into the upper half when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    logic [WIDTH:0]       mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // Restoring divide step: shift the next dividend bit into the remainder and try a
    // subtract. Borrow out of bit WIDTH means the trial went negative.
    logic [WIDTH:0]       div_sh, div_diff;
    logic                 div_ge;
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge   = ~div_diff[WIDTH];

    // Sign fixup terms used only in the FIX state.
    logic [2*WIDTH-1:0]   prod_s, hilo;
    logic [WIDTH-1:0]     quo_s, rem_s, dvz_hi;
    assign hilo   = {hi_q, lo_q};
    assign prod_s = qneg_q ? -acc_q : acc_q;
    assign quo_s  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // On divide-by-zero the dividend magnitude is left untouched, so re-signing it
    // recovers the original rs value (including the most-negative number).
    assign dvz_hi = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    // State and datapath registers, all cleared by asynchronous reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvz_q   <= dvz_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update: issue in IDLE, iterate in MUL/DIV, commit in FIX.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        op_d    = op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dvz_d   = dvz_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            opnd_d  = a_mag;
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            qneg_d  = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            rneg_d  = 1'b0;
                            dvz_d   = 1'b0;
                            op_d    = Op;
                            cnt_d   = '0;
                            state_d = S_MUL;
                        end
                        default: begin // OP_DIV, OP_DIVU
                            opnd_d  = b_mag;
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            qneg_d  = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            rneg_d  = is_signed & A[WIDTH-1];
                            dvz_d   = (B == '0);
                            op_d    = Op;
                            cnt_d   = '0;
                            state_d = S_DIV;
                        end
                    endcase
                end
            end

            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DIV: begin
                // Divide-by-zero still spends the full iteration window so latency is fixed.
                if (!dvz_q) begin
                    acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ge};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_FIX: begin
                case (op_q)
                    OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_s;
                    OP_MADD:           {hi_d, lo_d} = hilo + prod_s;
                    OP_MSUB:           {hi_d, lo_d} = hilo - prod_s;
                    OP_DIV, OP_DIVU: begin
                        if (dvz_q) begin
                            hi_d = dvz_hi;
                            lo_d = '1;
                        end else begin
                            hi_d = rem_s;
                            lo_d = quo_s;
                        end
                    end
                    default: ;
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_q;
    assign HiData = hi_q;
    assign LoData = lo_q;

endmodule
